processor: RTL and testbench



---
 rtl/processor.sv | 224 ++++++++++++++++++++++
 tb/tb_processor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/processor.sv
// ============================================================================
//  Module      : processor (with InstructionLoader, InstructionMemory, Processor)
//  Description : Built-in program loader, instruction log memory and 8-bit ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module InstructionLoader #(
    parameter int PROGRAM_LENGTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  opcode,
    output logic [7:0]  operand1,
    output logic [7:0]  operand2,
    output logic        done,
    output logic        write_enable,
    output logic [7:0]  address,
    output logic [23:0] data_out
);
    localparam int IDX_W = $clog2(PROGRAM_LENGTH + 1);
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(PROGRAM_LENGTH);

    logic [IDX_W-1:0] r_index;
    logic [23:0]      w_word;

    always_comb begin
        w_word = 24'h000000;
        case (8'(r_index))
            8'd0:    w_word = 24'h010503;
            8'd1:    w_word = 24'h020305;
            8'd2:    w_word = 24'h03F03C;
            8'd3:    w_word = 24'h040FF0;
            8'd4:    w_word = 24'h05AAAA;
            8'd5:    w_word = 24'h01FF01;
            8'd6:    w_word = 24'h078101;
            8'd7:    w_word = 24'h017F01;
            default: w_word = 24'h000000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index      <= '0;
            opcode       <= 8'h00;
            operand1     <= 8'h00;
            operand2     <= 8'h00;
            done         <= 1'b0;
            write_enable <= 1'b0;
            address      <= 8'h00;
            data_out     <= 24'h000000;
        end else if (r_index < c_LAST) begin
            {opcode, operand1, operand2} <= w_word;
            data_out     <= w_word;
            address      <= 8'(r_index);
            write_enable <= 1'b1;
            r_index      <= r_index + IDX_W'(1);
        end else begin
            // X operands mark end of program; index stays parked until reset
            opcode       <= 8'bx;
            operand1     <= 8'bx;
            operand2     <= 8'bx;
            write_enable <= 1'b0;
            done         <= 1'b1;
        end
    end
endmodule

module InstructionMemory (
    input  logic        clk,
    input  logic [7:0]  address,
    input  logic        write_enable,
    input  logic [23:0] data_in,
    output logic [23:0] data_out
);
    logic [23:0] r_mem [0:255] = '{default: 24'h000000};

    always_ff @(posedge clk) begin
        if (write_enable)
            r_mem[address] <= data_in;
    end

    assign data_out = r_mem[address];
endmodule

module Processor (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic [7:0] operand1,
    input  logic [7:0] operand2,
    output logic [7:0] result,
    output logic [3:0] flags
);
    logic [8:0]  w_sum;
    logic [7:0]  w_diff;
    logic [8:0]  w_shl;
    logic [8:0]  w_shr;
    logic [15:0] w_prod;
    logic [7:0]  w_res;
    logic        w_c;
    logic        w_v;
    logic        w_upd;

    // Shifts carry an extra bit so the last bit shifted out lands at a fixed position
    assign w_sum  = {1'b0, operand1} + {1'b0, operand2};
    assign w_diff = operand1 - operand2;
    assign w_shl  = {1'b0, operand1} << operand2[2:0];
    assign w_shr  = {operand1, 1'b0} >> operand2[2:0];
    assign w_prod = operand1 * operand2;

    always_comb begin
        w_res = 8'h00;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_upd = 1'b1;
        case (opcode)
            8'h01: begin
                w_res = w_sum[7:0];
                w_c   = w_sum[8];
                w_v   = (operand1[7] == operand2[7]) && (w_sum[7] != operand1[7]);
            end
            8'h02: begin
                w_res = w_diff;
                w_c   = operand1 < operand2;
                w_v   = (operand1[7] != operand2[7]) && (w_diff[7] != operand1[7]);
            end
            8'h03: w_res = operand1 & operand2;
            8'h04: w_res = operand1 | operand2;
            8'h05: w_res = operand1 ^ operand2;
            8'h06: w_res = ~operand1;
            8'h07: begin
                w_res = w_shl[7:0];
                w_c   = w_shl[8];
            end
            8'h08: begin
                w_res = w_shr[8:1];
                w_c   = w_shr[0];
            end
            8'h09: begin
                w_res = w_prod[7:0];
                w_c   = |w_prod[15:8];
            end
            default: w_upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= 8'h00;
            flags  <= 4'h0;
        end else if (w_upd) begin
            result <= w_res;
            flags  <= {w_v, w_res[7], w_c, (w_res == 8'h00)};
        end
    end
endmodule

module processor #(
    parameter int PROGRAM_LENGTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ext_sel,
    input  logic [7:0]  i_ext_opcode,
    input  logic [7:0]  i_ext_operand1,
    input  logic [7:0]  i_ext_operand2,
    input  logic [7:0]  i_mem_addr,
    output logic [7:0]  o_opcode,
    output logic [7:0]  o_operand1,
    output logic [7:0]  o_operand2,
    output logic        o_done,
    output logic        o_write_enable,
    output logic [7:0]  o_address,
    output logic [23:0] o_instr,
    output logic [23:0] o_mem_data,
    output logic [7:0]  o_result,
    output logic [3:0]  o_flags
);
    logic [7:0] w_alu_opcode;
    logic [7:0] w_alu_op1;
    logic [7:0] w_alu_op2;
    logic [7:0] w_mem_addr;

    InstructionLoader #(.PROGRAM_LENGTH(PROGRAM_LENGTH)) u_loader (
        .clk          (clk),
        .reset        (reset),
        .opcode       (o_opcode),
        .operand1     (o_operand1),
        .operand2     (o_operand2),
        .done         (o_done),
        .write_enable (o_write_enable),
        .address      (o_address),
        .data_out     (o_instr)
    );

    // Memory follows the loader while it writes, otherwise the external read port
    assign w_mem_addr = o_write_enable ? o_address : i_mem_addr;

    InstructionMemory u_mem (
        .clk          (clk),
        .address      (w_mem_addr),
        .write_enable (o_write_enable),
        .data_in      (o_instr),
        .data_out     (o_mem_data)
    );

    // After end of program the ALU sees a NOP so the X marker never reaches it
    assign w_alu_opcode = i_ext_sel ? i_ext_opcode   : (o_done ? 8'h00 : o_opcode);
    assign w_alu_op1    = i_ext_sel ? i_ext_operand1 : o_operand1;
    assign w_alu_op2    = i_ext_sel ? i_ext_operand2 : o_operand2;

    Processor u_alu (
        .clk      (clk),
        .reset    (reset),
        .opcode   (w_alu_opcode),
        .operand1 (w_alu_op1),
        .operand2 (w_alu_op2),
        .result   (o_result),
        .flags    (o_flags)
    );
endmodule

`default_nettype wire

// File: tb/tb_processor.sv
// ============================================================================
//  Module      : tb_processor
//  Description : Directed self-checking bench for the processor subsystem.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_processor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_ext_sel = 1'b0;
    logic [7:0]  i_ext_opcode = 8'h00;
    logic [7:0]  i_ext_operand1 = 8'h00;
    logic [7:0]  i_ext_operand2 = 8'h00;
    logic [7:0]  i_mem_addr = 8'h00;
    logic [7:0]  o_opcode, o_operand1, o_operand2, o_address, o_result;
    logic        o_done, o_write_enable;
    logic [23:0] o_instr, o_mem_data;
    logic [3:0]  o_flags;

    int total = 0;
    int bad   = 0;

    logic [23:0] rom_exp [0:7] = '{24'h010503, 24'h020305, 24'h03F03C, 24'h040FF0,
                                   24'h05AAAA, 24'h01FF01, 24'h078101, 24'h017F01};
    logic [7:0]  res_exp [0:7] = '{8'h08, 8'hFE, 8'h30, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h80};
    logic [3:0]  flg_exp [0:7] = '{4'b0000, 4'b0110, 4'b0000, 4'b0100,
                                   4'b0001, 4'b0011, 4'b0010, 4'b1100};

    processor dut (
        .clk            (clk),
        .reset          (reset),
        .i_ext_sel      (i_ext_sel),
        .i_ext_opcode   (i_ext_opcode),
        .i_ext_operand1 (i_ext_operand1),
        .i_ext_operand2 (i_ext_operand2),
        .i_mem_addr     (i_mem_addr),
        .o_opcode       (o_opcode),
        .o_operand1     (o_operand1),
        .o_operand2     (o_operand2),
        .o_done         (o_done),
        .o_write_enable (o_write_enable),
        .o_address      (o_address),
        .o_instr        (o_instr),
        .o_mem_data     (o_mem_data),
        .o_result       (o_result),
        .o_flags        (o_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        release_reset();
        tick(); tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({o_opcode, o_operand1, o_operand2, o_address} !== 32'h0 ||
            o_instr !== 24'h0 || o_write_enable !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_loader: got op=%h %h %h addr=%h data=%h we=%b done=%b, want all 0",
                     o_opcode, o_operand1, o_operand2, o_address, o_instr, o_write_enable, o_done);
        end
        total++;
        if (o_result !== 8'h00 || o_flags !== 4'h0) begin
            bad++;
            $display("FAIL reset_alu: got result=%h flags=%b, want 00/0000", o_result, o_flags);
        end
    endtask

    task automatic test_program();
        release_reset();
        tick();
        total++;
        if ({o_opcode, o_operand1, o_operand2} !== rom_exp[0] || o_instr !== rom_exp[0] ||
            o_address !== 8'h00 || o_write_enable !== 1'b1 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL first_issue: got %h%h%h data=%h addr=%h we=%b done=%b, want %h addr=00 we=1 done=0",
                     o_opcode, o_operand1, o_operand2, o_instr, o_address, o_write_enable, o_done, rom_exp[0]);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (o_result !== res_exp[k] || o_flags !== flg_exp[k]) begin
                bad++;
                $display("FAIL alu_instr%0d: got %h/%b, want %h/%b",
                         k, o_result, o_flags, res_exp[k], flg_exp[k]);
            end
            if (k == 6) begin
                total++;
                if (o_done !== 1'b0 || o_write_enable !== 1'b1 || o_address !== 8'h07) begin
                    bad++;
                    $display("FAIL pre_done: got done=%b we=%b addr=%h, want 0/1/07",
                             o_done, o_write_enable, o_address);
                end
            end
        end
        total++;
        if (o_done !== 1'b1 || o_write_enable !== 1'b0) begin
            bad++;
            $display("FAIL done_rise: got done=%b we=%b, want 1/0", o_done, o_write_enable);
        end
    endtask

    task automatic test_memory();
        for (int a = 0; a < 9; a++) begin
            logic [23:0] want;
            want = (a < 8) ? rom_exp[a] : 24'h000000;
            i_mem_addr = 8'(a);
            #1;
            total++;
            if (o_mem_data !== want) begin
                bad++;
                $display("FAIL mem_addr%0d: got %h, want %h", a, o_mem_data, want);
            end
        end
    endtask

    task automatic test_end();
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if (o_done !== 1'b1 || o_write_enable !== 1'b0 ||
                o_result !== 8'h80 || o_flags !== 4'b1100) begin
                bad++;
                $display("FAIL end_hold%0d: got done=%b we=%b %h/%b, want 1/0 80/1100",
                         n, o_done, o_write_enable, o_result, o_flags);
            end
        end
        i_mem_addr = 8'h07;
        #1;
        total++;
        if (o_mem_data !== 24'h017F01) begin
            bad++;
            $display("FAIL no_write_after_done: got %h, want 017F01", o_mem_data);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reset = 1'b1;
        release_reset();
        tick(); tick(); tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (o_result !== 8'h00 || o_opcode !== 8'h00 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got result=%h op=%h done=%b, want 00/00/0",
                     o_result, o_opcode, o_done);
        end
        release_reset();
        tick();
        total++;
        if ({o_opcode, o_operand1, o_operand2} !== 24'h010503 || o_address !== 8'h00) begin
            bad++;
            $display("FAIL restart_issue: got %h%h%h addr=%h, want 010503 addr=00",
                     o_opcode, o_operand1, o_operand2, o_address);
        end
        tick();
        total++;
        if (o_result !== 8'h08 || o_flags !== 4'b0000) begin
            bad++;
            $display("FAIL restart_result: got %h/%b, want 08/0000", o_result, o_flags);
        end
    endtask

    task automatic test_unknown_nop();
        @(negedge clk);
        i_ext_sel      = 1'b1;
        i_ext_opcode   = 8'hF0;
        i_ext_operand1 = 8'h12;
        i_ext_operand2 = 8'h34;
        tick();
        total++;
        if (o_result !== 8'h08 || o_flags !== 4'b0000) begin
            bad++;
            $display("FAIL unknown_op: got %h/%b, want 08/0000", o_result, o_flags);
        end
        @(negedge clk);
        i_ext_opcode = 8'h00;
        tick();
        total++;
        if (o_result !== 8'h08 || o_flags !== 4'b0000) begin
            bad++;
            $display("FAIL nop_op: got %h/%b, want 08/0000", o_result, o_flags);
        end
        @(negedge clk);
        i_ext_opcode   = 8'h08;
        i_ext_operand1 = 8'h81;
        i_ext_operand2 = 8'h01;
        tick();
        total++;
        if (o_result !== 8'h40 || o_flags !== 4'b0010) begin
            bad++;
            $display("FAIL shr_op: got %h/%b, want 40/0010", o_result, o_flags);
        end
        @(negedge clk);
        i_ext_opcode   = 8'h09;
        i_ext_operand1 = 8'h10;
        i_ext_operand2 = 8'h11;
        tick();
        total++;
        if (o_result !== 8'h10 || o_flags !== 4'b0010) begin
            bad++;
            $display("FAIL mul_op: got %h/%b, want 10/0010", o_result, o_flags);
        end
        @(negedge clk);
        i_ext_opcode   = 8'h06;
        i_ext_operand1 = 8'h0F;
        tick();
        total++;
        if (o_result !== 8'hF0 || o_flags !== 4'b0100) begin
            bad++;
            $display("FAIL not_op: got %h/%b, want F0/0100", o_result, o_flags);
        end
        i_ext_sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_program();
        test_memory();
        test_end();
        test_reset_mid();
        test_unknown_nop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
